// File: rtl/regfile_pkg.sv
// Shared defaults, types and the byte-strobe helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int DEF_NRD   = 2;
  localparam int DEF_NWR   = 2;

  typedef logic [DEF_DW-1:0] word_t;
  typedef logic [DEF_AW-1:0] addr_t;

  function automatic word_t strb_expand(input logic [DEF_DW/8-1:0] strb);
    word_t mask;
    for (int b = 0; b < DEF_DW/8; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush,
// plus per-read-port busy flags for decode hazard detection.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int NRD     = DEF_NRD,
  parameter int NWR     = DEF_NWR,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              flush,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [DEPTH-1:0]  pending,
  output logic [NRD-1:0]    rbusy
);

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [DEPTH-1:0] w_wr_hit;
  logic [NRD-1:0]   w_rd_hit;

  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && (waddr[w*AW +: AW] == AW'(r))) w_wr_hit[r] = 1'b1;
      end
    end
  end

  // flush beats issue, issue beats a same-cycle retire
  always_comb begin
    w_pend_nxt = r_pending;
    for (int r = 0; r < DEPTH; r++) begin
      if (flush)                                 w_pend_nxt[r] = 1'b0;
      else if (set_en && (set_addr == AW'(r)))   w_pend_nxt[r] = 1'b1;
      else if (w_wr_hit[r])                      w_pend_nxt[r] = 1'b0;
    end
    if (ZERO_R0 != 0) w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pend_nxt;
  end

  always_comb begin
    w_rd_hit = '0;
    rbusy    = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && (waddr[w*AW +: AW] == raddr[p*AW +: AW])) w_rd_hit[p] = 1'b1;
      end
      rbusy[p] = r_pending[raddr[p*AW +: AW]] && !w_rd_hit[p];
      if ((ZERO_R0 != 0) && (raddr[p*AW +: AW] == '0)) rbusy[p] = 1'b0;
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-strobed writes, same-cycle write-through to the read
// ports and a pending-write scoreboard for RAW hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int NRD     = DEF_NRD,
  parameter int NWR     = DEF_NWR,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DW-1:0]     rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DW-1:0]     wdata,
  input  logic [NWR*DW/8-1:0]   wstrb,
  input  logic                  set_en,
  input  logic [AW-1:0]         set_addr,
  input  logic                  flush,
  output logic [DEPTH-1:0]      pending
);

  localparam int NB = DW / 8;

  logic [DW-1:0]  r_mem    [DEPTH];
  logic [DW-1:0]  w_merged [DEPTH];
  logic [NWR-1:0] w_we;

  // Writes presented while reset is high must not leak through the bypass.
  assign w_we = reset ? '0 : we;

  // Ports are visited oldest first so the youngest matching byte lands last.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_merged[r] = r_mem[r];
      for (int w = 0; w < NWR; w++) begin
        if (w_we[w] && (waddr[w*AW +: AW] == AW'(r))) begin
          for (int b = 0; b < NB; b++) begin
            if (wstrb[w*NB + b]) w_merged[r][b*8 +: 8] = wdata[w*DW + b*8 +: 8];
          end
        end
      end
      if ((ZERO_R0 != 0) && (r == 0)) w_merged[r] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= w_merged[r];
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      rdata[p*DW +: DW] = w_merged[raddr[p*AW +: AW]];
    end
  end

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (set_addr),
    .flush    (flush),
    .we       (we),
    .waddr    (waddr),
    .raddr    (raddr),
    .pending  (pending),
    .rbusy    (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp: write merge, bypass, scoreboard, flush, r0, reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   raddr;
  logic [63:0]  rdata;
  logic [1:0]   rbusy;
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [63:0]  wdata;
  logic [7:0]   wstrb;
  logic         set_en;
  logic [4:0]   set_addr;
  logic         flush;
  logic [31:0]  pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk      (clk),
    .reset    (reset),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .set_en   (set_en),
    .set_addr (set_addr),
    .flush    (flush),
    .pending  (pending)
  );

  typedef struct {
    logic [1:0] we;
    addr_t      wa0, wa1;
    word_t      wd0, wd1;
    logic [3:0] ws0, ws1;
    addr_t      ra0, ra1;
    logic       set_en;
    addr_t      sa;
    logic       flush;
    word_t      e_rd0, e_rd1;
    logic [1:0] e_rb;
    logic [31:0] e_pend;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] we_i, input addr_t wa0, input word_t wd0,
                              input logic [3:0] ws0, input addr_t wa1, input word_t wd1,
                              input logic [3:0] ws1, input addr_t ra0, input addr_t ra1,
                              input logic se, input addr_t sa, input logic fl,
                              input word_t e0, input word_t e1, input logic [1:0] erb,
                              input logic [31:0] ep);
    vec_t v;
    v.we = we_i; v.wa0 = wa0; v.wd0 = wd0; v.ws0 = ws0;
    v.wa1 = wa1; v.wd1 = wd1; v.ws1 = ws1;
    v.ra0 = ra0; v.ra1 = ra1; v.set_en = se; v.sa = sa; v.flush = fl;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb = erb; v.e_pend = ep;
    return v;
  endfunction

  task automatic drive_idle();
    we = '0; waddr = '0; wdata = '0; wstrb = '0;
    set_en = 1'b0; set_addr = '0; flush = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    we = v.we;
    waddr = {v.wa1, v.wa0};
    wdata = {v.wd1, v.wd0};
    wstrb = {v.ws1, v.ws0};
    raddr = {v.ra1, v.ra0};
    set_en = v.set_en; set_addr = v.sa; flush = v.flush;
    #1;
    check32($sformatf("v%0d rdata0", idx), rdata[31:0], v.e_rd0);
    check32($sformatf("v%0d rdata1", idx), rdata[63:32], v.e_rd1);
    check32($sformatf("v%0d rbusy", idx), {30'd0, rbusy}, {30'd0, v.e_rb});
    @(posedge clk);
    #1;
    check32($sformatf("v%0d pending", idx), pending, v.e_pend);
  endtask

  vec_t tbl [19];

  initial begin
    //           we    wa0 wd0           ws0  wa1 wd1           ws1  ra0 ra1 se sa fl  rd0           rd1           rb     pend
    tbl[0]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 5,  0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0);
    tbl[1]  = mk(2'b11, 3, 32'h11111111, 4'hF, 3, 32'h22222222, 4'h3, 3,  3, 0, 0, 0, 32'h11112222, 32'h11112222, 2'b00, 32'h0);
    tbl[2]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 3,  7, 0, 0, 0, 32'h11112222, 32'h0,        2'b00, 32'h0);
    tbl[3]  = mk(2'b01, 7, 32'hAAAA0000, 4'hF, 0, 32'h0,        4'h0, 7,  3, 0, 0, 0, 32'hAAAA0000, 32'h11112222, 2'b00, 32'h0);
    tbl[4]  = mk(2'b10, 7, 32'hFFFFFFFF, 4'hF, 7, 32'h000055AA, 4'h1, 7,  7, 0, 0, 0, 32'hAAAA00AA, 32'hAAAA00AA, 2'b00, 32'h0);
    tbl[5]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 7,  3, 0, 0, 0, 32'hAAAA00AA, 32'h11112222, 2'b00, 32'h0);
    tbl[6]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 9,  9, 1, 9, 0, 32'h0,        32'h0,        2'b00, 32'h00000200);
    tbl[7]  = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 9,  9, 0, 0, 0, 32'h0,        32'h0,        2'b11, 32'h00000200);
    tbl[8]  = mk(2'b10, 0, 32'h0,        4'h0, 9, 32'h12345678, 4'hF, 9,  3, 0, 0, 0, 32'h12345678, 32'h11112222, 2'b00, 32'h0);
    tbl[9]  = mk(2'b01, 9, 32'hCAFEF00D, 4'h0, 0, 32'h0,        4'h0, 9,  9, 1, 9, 0, 32'h12345678, 32'h12345678, 2'b00, 32'h00000200);
    tbl[10] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 9,  3, 0, 0, 0, 32'h12345678, 32'h11112222, 2'b01, 32'h00000200);
    tbl[11] = mk(2'b01, 9, 32'hCAFEF00D, 4'h0, 0, 32'h0,        4'h0, 9,  9, 0, 0, 0, 32'h12345678, 32'h12345678, 2'b00, 32'h0);
    tbl[12] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 4,  0, 1, 4, 0, 32'h0,        32'h0,        2'b00, 32'h00000010);
    tbl[13] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 4,  6, 1, 6, 0, 32'h0,        32'h0,        2'b01, 32'h00000050);
    tbl[14] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 6,  8, 1, 8, 1, 32'h0,        32'h0,        2'b01, 32'h0);
    tbl[15] = mk(2'b11, 0, 32'hFFFFFFFF, 4'hF, 0, 32'hFFFFFFFF, 4'hF, 0,  0, 1, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0);
    tbl[16] = mk(2'b00, 0, 32'h0,        4'h0, 0, 32'h0,        4'h0, 0,  8, 0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0);
    tbl[17] = mk(2'b11, 12,32'h0000BEEF, 4'h3, 12,32'h12340000, 4'hC, 12, 12,0, 0, 0, 32'h1234BEEF, 32'h1234BEEF, 2'b00, 32'h0);
    tbl[18] = mk(2'b11, 20,32'h01020304, 4'hF, 21,32'h05060708, 4'hF, 20, 21,0, 0, 0, 32'h01020304, 32'h05060708, 2'b00, 32'h0);

    reset = 1'b1;
    raddr = '0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check32("reset rdata0", rdata[31:0], 32'h0);
    check32("reset pending", pending, 32'h0);

    for (int i = 0; i < 19; i++) apply(i, tbl[i]);

    // Asynchronous reset mid-cycle clears array and scoreboard before the next edge.
    @(negedge clk);
    drive_idle();
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF}; wstrb = 8'h0F;
    set_en = 1'b1; set_addr = 5'd5; raddr = {5'd5, 5'd5};
    @(posedge clk);
    #1;
    drive_idle();
    #1;
    check32("pre-reset r5", rdata[31:0], 32'hDEADBEEF);
    check32("pre-reset pending", pending, 32'h00000020);
    check32("pre-reset rbusy", {30'd0, rbusy}, 32'h3);
    #1;
    reset = 1'b1;
    #1;
    check32("async reset r5", rdata[31:0], 32'h0);
    check32("async reset pending", pending, 32'h0);
    check32("async reset rbusy", {30'd0, rbusy}, 32'h0);
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h55555555}; wstrb = 8'h0F;
    set_en = 1'b1; set_addr = 5'd5;
    #1;
    check32("write during reset bypass", rdata[31:0], 32'h0);
    @(posedge clk);
    #1;
    check32("write during reset stored", rdata[31:0], 32'h0);
    check32("set during reset", pending, 32'h0);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    check32("post-reset r5", rdata[31:0], 32'h0);
    check32("post-reset r3", rdata[63:32], 32'h0);
    raddr = {5'd7, 5'd3};
    #1;
    check32("post-reset r3 port0", rdata[31:0], 32'h0);
    check32("post-reset r7 port1", rdata[63:32], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined CPU core.

- Provides NRD combinational read ports and NWR write ports with byte strobes.
- Forwards same-cycle writes to the read ports.
- Tracks a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight producers.
- Successor to the single-write, two-read register file; sits between decode (reads, issue) and writeback (writes).

## Interface
- DW, 32: data width in bits; a multiple of 8.
- DEPTH, 32: number of registers; a power of two.
- AW, $clog2(DEPTH): address width.
- NRD, 2: number of read ports.
- NWR, 2: number of write ports; a higher index is the younger instruction.
- ZERO_R0, 1: when 1, register 0 reads as zero, ignores writes and is never pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- raddr  in  NRD*AW  read addresses, port p at [p*AW +: AW].
- rdata  out  NRD*DW  read data, port p at [p*DW +: DW].
- rbusy  out  NRD  read port p's register is pending and is not being written this cycle.
- we  in  NWR  write enables.
- waddr  in  NWR*AW  write addresses.
- wdata  in  NWR*DW  write data.
- wstrb  in  NWR*DW/8  byte strobes; a byte is written only when both we and its strobe are 1.
- set_en  in  1  issue marks set_addr as pending.
- set_addr  in  AW  destination of the issued instruction.
- flush  in  1  synchronous clear of all pending bits.
- pending  out  DEPTH  scoreboard vector, bit r = register r pending.

## Operation
- Storage: DEPTH×DW register array plus a DEPTH-bit pending vector.
- Write merge, resolved per register per byte:
  - Final byte = wdata byte of the highest-index port with we, matching address and strobe set.
  - Otherwise the byte keeps its stored value.
- Read, combinational, per port p:
  - If ZERO_R0 and raddr==0: rdata=0, rbusy=0.
  - Otherwise rdata = stored value with this cycle's merged write bytes overlaid (write-through bypass).
- Busy rule: rbusy[p] = pending[raddr_p] and no port has we=1 to raddr_p this cycle.
  - A write to the address clears busy even with wstrb=0 (a full-strobe-zero write still retires the producer).
- Pending update at the rising edge, per register r, first match wins:
  1. flush=1: 0.
  2. set_en=1 and set_addr==r: 1. A new producer overrides a same-cycle retire.
  3. Any we to r: 0.
  4. Otherwise hold.
- ZERO_R0 = 1: writes to register 0 are discarded and pending[0] is held at 0.
- set_en and flush together: flush wins, so the issue is squashed.
- Addresses are always in range (DEPTH = 2^AW); no out-of-range behaviour is needed.

## Timing
- Reset asserted, asynchronously:
  - Every register is 0 and pending is 0.
  - rdata then reads 0 and rbusy is 0 for any address.
  - Writes, set and flush are ignored while reset is high.
- Release is synchronised externally; the first active edge is the first clk edge after reset deasserts.
- Read latency: 0 cycles; combinational from raddr, we, waddr, wdata, wstrb and the stored state.
- Write latency: bypassed in the same cycle; in the array from the next edge.
- Scoreboard: set_en at edge N gives pending=1 after edge N. A write at edge M > N gives rbusy=0 during cycle M and pending=0 after edge M.
- Reset mid-operation: an in-flight set or write on the reset cycle is lost.
- No multicycle paths; every output is valid within the cycle.

## Structure
- Package regfile_pkg holds:
  - Default DW, DEPTH and NRD/NWR values.
  - Helper function strb_expand (DW/8 strobe to DW mask).
  - Typedefs for the data word and the register address.
- Sub-module rf_scoreboard: the pending vector, its set/clear/flush priority and the rbusy generation.
- The top level holds the array, the write-merge logic and the read bypass.

## Test plan
- Reset: write 0xDEADBEEF to r5 on port 0, then assert reset between clock edges → rdata(r5)=0 and pending=0 immediately, before the next edge.
- Dual write, same register: port0 writes r3=0x11111111 with strb 1111 and port1 writes r3=0x2222_2222 with strb 0011 in the same cycle. Required:
  - Same cycle, read r3 = 0x11112222.
  - After the edge, read r3 = 0x11112222.
- Bypass: r7 holds 0xAAAA0000; port1 writes 0x000055AA with strb 0001 → same-cycle read r7 = 0xAAAA00AA.
- Scoreboard:
  - set_en on r9 → rbusy=1 on the following cycles.
  - Write r9 → rbusy=0 in that same cycle; pending[9]=0 after the edge.
  - set_en and a write to r9 in the same cycle → pending[9]=1.
- Flush and r0 (ZERO_R0=1):
  - Set r4 and r6 pending, then flush together with set_en r8 → pending all 0.
  - Write 0xFFFFFFFF to r0 → r0 reads 0 and is never busy.
